queue_ctrl_4x4b: RTL and testbench

Control stage for a 4-entry, 4-bit FIFO. It drives the write and read ports of the flat 1r1w 4x4b register file used as FIFO storage, and consumes that file's combinational read data. It presents valid/ready enqueue and dequeue interfaces to the surrounding datapath. It owns the head/tail pointers, occupancy count and full/empty FSM; the register file holds only data.

---
 rtl/queue_ctrl_pkg.sv | 21 ++
 rtl/queue_ptr_ctr.sv | 26 ++
 rtl/queue_ctrl_4x4b.sv | 140 ++++++++++++++
 tb/tb_queue_ctrl_4x4b.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/queue_ctrl_pkg.sv
// queue_ctrl_pkg: shared types and sizing constants for the 4-entry,
// 4-bit FIFO control stage (queue_ctrl_4x4b) and its pointer counters.
//   state_e : occupancy FSM encoding (EMPTY, MID, FULL)
//   DEPTH   : number of FIFO entries
//   PTR_W   : head/tail pointer width
//   CNT_W   : occupancy count width (holds 0..DEPTH)
//   MSG_W   : message width, equal to the register-file word width
package queue_ctrl_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    MID   = 2'd1,
    FULL  = 2'd2
  } state_e;

  localparam int DEPTH = 4;
  localparam int PTR_W = 2;
  localparam int CNT_W = PTR_W + 1;
  localparam int MSG_W = 4;

endpackage

// File: rtl/queue_ptr_ctr.sv
// queue_ptr_ctr: wrap-around pointer register used for the FIFO head and
// tail. Resets asynchronously to 0 and advances by one on each clock edge
// where inc is high, wrapping from 2**p_naddr-1 back to 0.
//   clk   in  clock
//   rst_n in  asynchronous active-low reset
//   inc   in  advance the pointer this cycle
//   ptr   out current pointer value
module queue_ptr_ctr #(
  parameter int p_naddr = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               inc,
  output logic [p_naddr-1:0] ptr
);

  // The natural overflow of the p_naddr-bit add gives the modulo wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= ptr + 1'b1;
    end
  end

endmodule

// File: rtl/queue_ctrl_4x4b.sv
// queue_ctrl_4x4b: control stage for a 4-entry, 4-bit FIFO whose data
// lives in an external flat 1r1w register file. This block owns the
// head/tail pointers, the occupancy count and the EMPTY/MID/FULL FSM.
//
// Handshakes: a transfer happens on a rising clock edge where both valid
// and ready are high. enq_rdy never depends on enq_val; deq_val never
// depends on deq_rdy. A sender holding valid keeps its message stable
// until the transfer happens.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   enq_val/enq_rdy/enq_msg  upstream valid/ready interface
//   deq_val/deq_rdy/deq_msg  downstream valid/ready interface
//   rf_wen/rf_waddr/rf_wdata register-file write port (tail)
//   rf_raddr/rf_rdata        register-file read port (head), rdata comb.
//   count                occupancy 0..4
//   state_dbg            current FSM state, for observation
//
// Build option: QUEUE_CTRL_BYPASS_EN lets a message arriving at an empty
// queue appear on deq_msg in the same cycle; if it is taken that cycle
// it never touches the register file.
module queue_ctrl_4x4b
  import queue_ctrl_pkg::*;
#(
  parameter int p_nbits = MSG_W,
  parameter int p_naddr = PTR_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enq_val,
  output logic               enq_rdy,
  input  logic [p_nbits-1:0] enq_msg,
  output logic               deq_val,
  input  logic               deq_rdy,
  output logic [p_nbits-1:0] deq_msg,
  output logic               rf_wen,
  output logic [p_naddr-1:0] rf_waddr,
  output logic [p_nbits-1:0] rf_wdata,
  output logic [p_naddr-1:0] rf_raddr,
  input  logic [p_nbits-1:0] rf_rdata,
  output logic [p_naddr:0]   count,
  output state_e             state_dbg
);

  localparam logic [p_naddr:0] CNT_ONE  = (p_naddr+1)'(1);
  localparam logic [p_naddr:0] CNT_LAST = (p_naddr+1)'((1 << p_naddr) - 1);

  state_e             state_q, state_d;
  logic [p_naddr:0]   count_q, count_d;
  logic [p_naddr-1:0] head, tail;
  logic               enq_fire, deq_fire;
  logic               pass;      // message bypasses storage entirely
  logic               do_write;  // message is stored at tail
  logic               do_read;   // head entry is consumed

  // Gating with rst_n keeps the upstream from seeing ready while reset
  // is holding the queue empty.
  assign enq_rdy = (state_q != FULL) & rst_n;

`ifdef QUEUE_CTRL_BYPASS_EN
  logic bypass;
  assign bypass  = (state_q == EMPTY) & enq_val & rst_n;
  assign deq_val = (state_q != EMPTY) | bypass;
  assign deq_msg = bypass ? enq_msg : rf_rdata;
  assign pass    = bypass & deq_rdy;
`else
  assign deq_val = (state_q != EMPTY);
  assign deq_msg = rf_rdata;
  assign pass    = 1'b0;
`endif

  assign enq_fire = enq_val & enq_rdy;
  assign deq_fire = deq_val & deq_rdy;
  assign do_write = enq_fire & ~pass;
  assign do_read  = deq_fire & ~pass;

  assign rf_wen   = do_write;
  assign rf_waddr = tail;
  assign rf_wdata = enq_msg;
  assign rf_raddr = head;

  assign count     = count_q;
  assign state_dbg = state_q;

  queue_ptr_ctr #(.p_naddr(p_naddr)) u_head (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (do_read),
    .ptr   (head)
  );

  queue_ptr_ctr #(.p_naddr(p_naddr)) u_tail (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (do_write),
    .ptr   (tail)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    count_d = count_q;
    if (do_write && !do_read) begin
      count_d = count_q + 1'b1;
    end else if (do_read && !do_write) begin
      count_d = count_q - 1'b1;
    end
  end

  // count_q is the pre-update occupancy, so the FULL/EMPTY edges are
  // detected one entry early.
  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY: begin
        if (do_write) state_d = MID;
      end
      MID: begin
        if (do_write && !do_read && count_q == CNT_LAST) begin
          state_d = FULL;
        end else if (do_read && !do_write && count_q == CNT_ONE) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (do_read) state_d = MID;
      end
      default: state_d = EMPTY;
    endcase
  end

endmodule

// File: tb/tb_queue_ctrl_4x4b.sv
// tb_queue_ctrl_4x4b: bench for queue_ctrl_4x4b with an attached 4x4b
// register file. A driver applies directed and random traffic and checks
// control outputs against an occupancy/pointer model; a monitor compares
// every dequeued message against the expected queue.
module tb_queue_ctrl_4x4b;
  import queue_ctrl_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       enq_val;
  logic       enq_rdy;
  logic [3:0] enq_msg;
  logic       deq_val;
  logic       deq_rdy;
  logic [3:0] deq_msg;
  logic       rf_wen;
  logic [1:0] rf_waddr;
  logic [3:0] rf_wdata;
  logic [1:0] rf_raddr;
  logic [3:0] rf_rdata;
  logic [2:0] count;
  state_e     state_dbg;

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  queue_ctrl_4x4b #(.p_nbits(4), .p_naddr(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enq_val   (enq_val),
    .enq_rdy   (enq_rdy),
    .enq_msg   (enq_msg),
    .deq_val   (deq_val),
    .deq_rdy   (deq_rdy),
    .deq_msg   (deq_msg),
    .rf_wen    (rf_wen),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .rf_raddr  (rf_raddr),
    .rf_rdata  (rf_rdata),
    .count     (count),
    .state_dbg (state_dbg)
  );

  // 1r1w register file: synchronous write, combinational read
  logic [3:0] mem [4];
  always_ff @(posedge clk) begin
    if (rf_wen) mem[rf_waddr] <= rf_wdata;
  end
  assign rf_rdata = mem[rf_raddr];

  // scoreboard state
  logic [3:0] exp_q[$];
  int errors = 0;
  int checks = 0;

  // reference model: occupancy and slot indices
  int mcount = 0;
  int mhead  = 0;
  int mtail  = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // driver: one cycle of stimulus plus control-output checks
  task automatic cycle(input logic ev, input logic [3:0] em, input logic dr);
    logic byp, pass, acc, pop;
    @(negedge clk);
    enq_val = ev;
    enq_msg = em;
    deq_rdy = dr;
    byp = 1'b0;
`ifdef QUEUE_CTRL_BYPASS_EN
    byp = ev && (mcount == 0);
`endif
    pass = byp && dr;
    acc  = ev && (mcount < 4);
    pop  = dr && (mcount > 0);
    if (acc) exp_q.push_back(em);
    #2;
    chk("enq_rdy", int'(enq_rdy), int'(mcount < 4));
    chk("deq_val", int'(deq_val), int'(mcount > 0 || byp));
    chk("count", int'(count), mcount);
    chk("rf_wen", int'(rf_wen), int'(acc && !pass));
    chk("rf_raddr", int'(rf_raddr), mhead);
    if (acc && !pass) begin
      chk("rf_waddr", int'(rf_waddr), mtail);
      chk("rf_wdata", int'(rf_wdata), int'(em));
    end
    @(posedge clk);
    if (!pass) begin
      if (acc) begin
        mtail = (mtail + 1) % 4;
        mcount++;
      end
      if (pop) begin
        mhead = (mhead + 1) % 4;
        mcount--;
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_enq_rdy"}, int'(enq_rdy), 0);
    chk({tag, "_deq_val"}, int'(deq_val), 0);
    chk({tag, "_rf_wen"}, int'(rf_wen), 0);
    chk({tag, "_rf_waddr"}, int'(rf_waddr), 0);
    chk({tag, "_rf_raddr"}, int'(rf_raddr), 0);
    chk({tag, "_count"}, int'(count), 0);
  endtask

  // monitor: compares each dequeued message with the expected queue
  always @(negedge clk) begin
    #3;
    if (deq_val === 1'b1 && deq_rdy === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("deq_unexpected", 1, 0);
      end else begin
        chk("deq_msg", int'(deq_msg), int'(exp_q.pop_front()));
      end
    end
  end

  // FSM state must agree with occupancy every cycle
  always @(negedge clk) begin
    #3;
    if (rst_n === 1'b1) begin
      chk("fsm_empty", int'(state_dbg == EMPTY), int'(count == 3'd0));
      chk("fsm_full", int'(state_dbg == FULL), int'(count == 3'd4));
    end
  end

  initial begin
    rst_n   = 1'b0;
    enq_val = 1'b1;
    enq_msg = 4'hF;
    deq_rdy = 1'b1;
    #12;
    check_reset_outputs("reset");
    @(negedge clk);
    #1 rst_n = 1'b1;
    enq_val = 1'b0;

    // idle after reset
    repeat (3) cycle(1'b0, 4'h0, 1'b0);

    // fill to full, then a rejected 5th enqueue
    for (int i = 1; i <= 4; i++) cycle(1'b1, 4'(i), 1'b0);
    cycle(1'b1, 4'h5, 1'b0);

    // drain from full
    repeat (5) cycle(1'b0, 4'h0, 1'b1);

    // steady stream, count stays 1, pointers wrap
    cycle(1'b1, 4'h0, 1'b0);
    for (int i = 1; i <= 9; i++) cycle(1'b1, 4'(i), 1'b1);
    cycle(1'b0, 4'h0, 1'b1);

    // reset mid-stream with three entries held
    for (int i = 0; i < 3; i++) cycle(1'b1, 4'(i + 6), 1'b0);
    @(negedge clk);
    enq_val = 1'b1;
    enq_msg = 4'hC;
    deq_rdy = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    mcount = 0;
    mhead  = 0;
    mtail  = 0;
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    #1 rst_n = 1'b1;
    enq_val = 1'b0;
    deq_rdy = 1'b0;
    cycle(1'b0, 4'h0, 1'b0);

    // enqueue 0xA into an empty queue with the consumer ready
    cycle(1'b1, 4'hA, 1'b1);
    cycle(1'b0, 4'h0, 1'b1);

    // random traffic: enqueue-heavy, then dequeue-heavy, then balanced
    for (int i = 0; i < 150; i++)
      cycle(1'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)),
            1'($urandom_range(0, 3) == 0));
    for (int i = 0; i < 150; i++)
      cycle(1'($urandom_range(0, 3) == 0), 4'($urandom_range(0, 15)),
            1'($urandom_range(0, 3) != 0));
    for (int i = 0; i < 200; i++)
      cycle(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
            1'($urandom_range(0, 1)));

    // drain and confirm nothing is left outstanding
    repeat (6) cycle(1'b0, 4'h0, 1'b1);
    @(negedge clk);
    #5;
    chk("exp_q_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
